axi_wr_arbiter: RTL and testbench

AXI_WR_ARBITER -- requirements
Module: axi_wr_arbiter

---
 rtl/axi_wr_arbiter_pkg.sv | 15 +
 rtl/axi_wr_arbiter_rr_pick.sv | 35 +++
 rtl/axi_wr_arbiter.sv | 151 +++++++++++++++
 tb/tb_axi_wr_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_wr_arbiter_pkg.sv
// Shared types and constants for the AXI write arbiter.
// Holds the FSM state encoding and AXI B response codes.
package axi_wr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr_i, wrapping.
// Ports: req_i (request vector), ptr_i (start index), gnt_o (one-hot), idx_o (index).
module axi_wr_arbiter_rr_pick #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  logic          found;
  int            pos;
  logic [IW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = 0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      pos = int'(ptr_i) + k;
      if (pos >= N) pos = pos - N;
      cand = IW'(pos);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/axi_wr_arbiter.sv
// N-to-1 AXI write arbiter, one transaction in flight, round-robin grant in IDLE.
// Ports: req_* per-requester AW/W/B, mst_* downstream AW/W/B, grant_o owner, busy_o.
module axi_wr_arbiter
  import axi_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_REQ-1:0]              req_aw_valid_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_aw_addr_i,
  output logic [NUM_REQ-1:0]              req_aw_ready_o,
  input  logic [NUM_REQ-1:0]              req_w_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_w_data_i,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_w_strb_i,
  input  logic [NUM_REQ-1:0]              req_w_last_i,
  output logic [NUM_REQ-1:0]              req_w_ready_o,
  output logic [NUM_REQ-1:0]              req_b_valid_o,
  output logic [1:0]                      req_b_resp_o,
  input  logic [NUM_REQ-1:0]              req_b_ready_i,
  output logic                            mst_aw_valid_o,
  output logic [ADDR_WIDTH-1:0]           mst_aw_addr_o,
  input  logic                            mst_aw_ready_i,
  output logic                            mst_w_valid_o,
  output logic [DATA_WIDTH-1:0]           mst_w_data_o,
  output logic [DATA_WIDTH/8-1:0]         mst_w_strb_o,
  output logic                            mst_w_last_o,
  input  logic                            mst_w_ready_i,
  input  logic                            mst_b_valid_i,
  input  logic [1:0]                      mst_b_resp_i,
  output logic                            mst_b_ready_o,
  output logic [NUM_REQ-1:0]              grant_o,
  output logic                            busy_o
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int SW = DATA_WIDTH / 8;

  state_e               state_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [IW-1:0]        gidx_q;
  logic [IW-1:0]        rr_ptr_q;
  logic [IW-1:0]        rr_ptr_d;

  logic [NUM_REQ-1:0]   pick_gnt;
  logic [IW-1:0]        pick_idx;

  logic                 sel_aw_valid;
  logic [ADDR_WIDTH-1:0] sel_aw_addr;
  logic                 sel_w_valid;
  logic [DATA_WIDTH-1:0] sel_w_data;
  logic [SW-1:0]        sel_w_strb;
  logic                 sel_w_last;
  logic                 sel_b_ready;

  logic st_addr;
  logic st_data;
  logic st_resp;

  axi_wr_arbiter_rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_pick (
    .req_i (req_aw_valid_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  // One-hot grant mux of the owner's channels.
  always_comb begin
    sel_aw_valid = 1'b0;
    sel_aw_addr  = '0;
    sel_w_valid  = 1'b0;
    sel_w_data   = '0;
    sel_w_strb   = '0;
    sel_w_last   = 1'b0;
    sel_b_ready  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        sel_aw_valid = req_aw_valid_i[i];
        sel_aw_addr  = req_aw_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_w_valid  = req_w_valid_i[i];
        sel_w_data   = req_w_data_i[i*DATA_WIDTH +: DATA_WIDTH];
        sel_w_strb   = req_w_strb_i[i*SW +: SW];
        sel_w_last   = req_w_last_i[i];
        sel_b_ready  = req_b_ready_i[i];
      end
    end
  end

  assign st_addr = (state_q == ST_ADDR);
  assign st_data = (state_q == ST_DATA);
  assign st_resp = (state_q == ST_RESP);

  assign rr_ptr_d = (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + IW'(1);

  assign mst_aw_valid_o = st_addr & sel_aw_valid;
  assign mst_aw_addr_o  = st_addr ? sel_aw_addr : '0;
  assign req_aw_ready_o = {NUM_REQ{st_addr & mst_aw_ready_i}} & grant_q;

  assign mst_w_valid_o  = st_data & sel_w_valid;
  assign mst_w_data_o   = st_data ? sel_w_data : '0;
  assign mst_w_strb_o   = st_data ? sel_w_strb : '0;
  assign mst_w_last_o   = st_data & sel_w_last;
  assign req_w_ready_o  = {NUM_REQ{st_data & mst_w_ready_i}} & grant_q;

  assign req_b_valid_o  = {NUM_REQ{st_resp & mst_b_valid_i}} & grant_q;
  assign req_b_resp_o   = st_resp ? mst_b_resp_i : RESP_OKAY;
  assign mst_b_ready_o  = st_resp & sel_b_ready;

  assign grant_o = grant_q;
  assign busy_o  = (state_q != ST_IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      gidx_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|req_aw_valid_i) begin
            grant_q <= pick_gnt;
            gidx_q  <= pick_idx;
            state_q <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (mst_aw_valid_o && mst_aw_ready_i) state_q <= ST_DATA;
        end
        ST_DATA: begin
          if (mst_w_valid_o && mst_w_ready_i && mst_w_last_o)
            state_q <= ST_RESP;
        end
        ST_RESP: begin
          if (mst_b_valid_i && mst_b_ready_o) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= rr_ptr_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Self-checking bench for axi_wr_arbiter: directed scenarios then random traffic.
// Reference: round-robin owner model, bench-side handshakes, expected pass-through.
module tb_axi_wr_arbiter;
  import axi_wr_arbiter_pkg::*;

  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic              clk = 1'b0;
  logic              rst_i;
  logic [NR-1:0]     req_aw_valid_i;
  logic [NR*AW-1:0]  req_aw_addr_i;
  logic [NR-1:0]     req_aw_ready_o;
  logic [NR-1:0]     req_w_valid_i;
  logic [NR*DW-1:0]  req_w_data_i;
  logic [NR*SW-1:0]  req_w_strb_i;
  logic [NR-1:0]     req_w_last_i;
  logic [NR-1:0]     req_w_ready_o;
  logic [NR-1:0]     req_b_valid_o;
  logic [1:0]        req_b_resp_o;
  logic [NR-1:0]     req_b_ready_i;
  logic              mst_aw_valid_o;
  logic [AW-1:0]     mst_aw_addr_o;
  logic              mst_aw_ready_i;
  logic              mst_w_valid_o;
  logic [DW-1:0]     mst_w_data_o;
  logic [SW-1:0]     mst_w_strb_o;
  logic              mst_w_last_o;
  logic              mst_w_ready_i;
  logic              mst_b_valid_i;
  logic [1:0]        mst_b_resp_i;
  logic              mst_b_ready_o;
  logic [NR-1:0]     grant_o;
  logic              busy_o;

  int n_cmp = 0;
  int n_err = 0;
  int ptr_m = 0;

  always #5 clk = ~clk;

  axi_wr_arbiter #(
    .NUM_REQ    (NR),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .req_aw_valid_i (req_aw_valid_i),
    .req_aw_addr_i  (req_aw_addr_i),
    .req_aw_ready_o (req_aw_ready_o),
    .req_w_valid_i  (req_w_valid_i),
    .req_w_data_i   (req_w_data_i),
    .req_w_strb_i   (req_w_strb_i),
    .req_w_last_i   (req_w_last_i),
    .req_w_ready_o  (req_w_ready_o),
    .req_b_valid_o  (req_b_valid_o),
    .req_b_resp_o   (req_b_resp_o),
    .req_b_ready_i  (req_b_ready_i),
    .mst_aw_valid_o (mst_aw_valid_o),
    .mst_aw_addr_o  (mst_aw_addr_o),
    .mst_aw_ready_i (mst_aw_ready_i),
    .mst_w_valid_o  (mst_w_valid_o),
    .mst_w_data_o   (mst_w_data_o),
    .mst_w_strb_o   (mst_w_strb_o),
    .mst_w_last_o   (mst_w_last_o),
    .mst_w_ready_i  (mst_w_ready_i),
    .mst_b_valid_i  (mst_b_valid_i),
    .mst_b_resp_i   (mst_b_resp_i),
    .mst_b_ready_o  (mst_b_ready_o),
    .grant_o        (grant_o),
    .busy_o         (busy_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first pending index searching upward from ptr.
  function automatic int pick(input logic [NR-1:0] m, input int p);
    for (int k = 0; k < NR; k++)
      if (m[(p + k) % NR]) return (p + k) % NR;
    return 0;
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, " busy"}, 64'(busy_o), 0);
    chk({tag, " grant"}, 64'(grant_o), 0);
    chk({tag, " aw_rdy"}, 64'(req_aw_ready_o), 0);
    chk({tag, " w_rdy"}, 64'(req_w_ready_o), 0);
    chk({tag, " b_vld"}, 64'(req_b_valid_o), 0);
    chk({tag, " m_awv"}, 64'(mst_aw_valid_o), 0);
    chk({tag, " m_wv"}, 64'(mst_w_valid_o), 0);
    chk({tag, " m_brdy"}, 64'(mst_b_ready_o), 0);
  endtask

  task automatic clear_inputs();
    req_aw_valid_i = '0;
    req_w_valid_i  = '0;
    req_w_last_i   = '0;
    req_b_ready_i  = '0;
    mst_aw_ready_i = 1'b0;
    mst_w_ready_i  = 1'b0;
    mst_b_valid_i  = 1'b0;
    mst_b_resp_i   = RESP_OKAY;
  endtask

  task automatic do_reset(input string tag);
    rst_i = 1'b1;
    @(negedge clk);
    #1;
    chk_quiet(tag);
    rst_i = 1'b0;
    ptr_m = 0;
  endtask

  task automatic raise(input int i, input logic [AW-1:0] a);
    req_aw_valid_i[i] = 1'b1;
    req_aw_addr_i[i*AW +: AW] = a;
  endtask

  task automatic drive_beat(input int w, input int b, input int nb,
                            input logic [DW-1:0] d0);
    req_w_valid_i[w] = 1'b1;
    req_w_data_i[w*DW +: DW] = d0 + DW'(b);
    req_w_strb_i[w*SW +: SW] = 4'hF ^ 4'(b);
    req_w_last_i[w] = (b == nb - 1);
  endtask

  // One full write through the arbiter. Entry: state IDLE with AW requests driven.
  task automatic do_txn(input string tag, input int nb, input logic [DW-1:0] d0,
                        input int aw_dly, input int wmode, input int b_dly,
                        input logic [1:0] resp, input logic [NR-1:0] late,
                        input int abort_at);
    int w;
    int acc;
    int cyc;
    int fwd;
    logic rdy;
    logic [NR-1:0] oh;
    logic [AW-1:0] exp_addr;
    w = pick(req_aw_valid_i, ptr_m);
    oh = NR'(1) << w;
    exp_addr = req_aw_addr_i[w*AW +: AW];
    #1;
    chk({tag, " idle grant"}, 64'(grant_o), 0);
    chk({tag, " idle busy"}, 64'(busy_o), 0);
    chk({tag, " idle aw_rdy"}, 64'(req_aw_ready_o), 0);
    @(negedge clk);
    // ADDR: W beat offered early must not be taken.
    for (int i = 0; i < NR; i++)
      if (i != w && req_aw_valid_i[i]) begin
        req_w_valid_i[i] = 1'b1;
        req_w_data_i[i*DW +: DW] = 32'hBAD0_0000 | DW'(i);
      end
    drive_beat(w, 0, nb, d0);
    mst_w_ready_i = 1'b1;
    for (int c = 0; c <= aw_dly; c++) begin
      mst_aw_ready_i = (c == aw_dly);
      #1;
      chk({tag, " a busy"}, 64'(busy_o), 1);
      chk({tag, " a grant"}, 64'(grant_o), 64'(oh));
      chk({tag, " a m_awv"}, 64'(mst_aw_valid_o), 1);
      chk({tag, " a addr"}, 64'(mst_aw_addr_o), 64'(exp_addr));
      chk({tag, " a aw_rdy"}, 64'(req_aw_ready_o),
          (c == aw_dly) ? 64'(oh) : 64'(0));
      chk({tag, " a w_rdy"}, 64'(req_w_ready_o), 0);
      chk({tag, " a m_wv"}, 64'(mst_w_valid_o), 0);
      @(negedge clk);
    end
    req_aw_valid_i[w] = 1'b0;
    mst_aw_ready_i = 1'b0;
    for (int i = 0; i < NR; i++)
      if (late[i] && !req_aw_valid_i[i]) raise(i, AW'($urandom));
    // DATA
    acc = 0;
    cyc = 0;
    fwd = 0;
    while (acc < nb) begin
      if (acc == abort_at) begin
        rst_i = 1'b1;
        @(negedge clk);
        #1;
        chk_quiet({tag, " rst"});
        rst_i = 1'b0;
        ptr_m = 0;
        clear_inputs();
        return;
      end
      case (wmode)
        0: rdy = 1'b1;
        1: rdy = (cyc % 2 == 0);
        default: rdy = (cyc > 12) ? 1'b1 : 1'($urandom_range(0, 1));
      endcase
      drive_beat(w, acc, nb, d0);
      mst_w_ready_i = rdy;
      #1;
      chk({tag, " d m_wv"}, 64'(mst_w_valid_o), 1);
      chk({tag, " d data"}, 64'(mst_w_data_o), 64'(d0 + DW'(acc)));
      chk({tag, " d strb"}, 64'(mst_w_strb_o), 64'(4'hF ^ 4'(acc)));
      chk({tag, " d last"}, 64'(mst_w_last_o), 64'(acc == nb - 1));
      chk({tag, " d w_rdy"}, 64'(req_w_ready_o), rdy ? 64'(oh) : 64'(0));
      chk({tag, " d aw_rdy"}, 64'(req_aw_ready_o), 0);
      chk({tag, " d m_awv"}, 64'(mst_aw_valid_o), 0);
      chk({tag, " d m_brdy"}, 64'(mst_b_ready_o), 0);
      if (mst_w_valid_o && mst_w_ready_i) fwd++;
      if (rdy) acc++;
      cyc++;
      @(negedge clk);
    end
    chk({tag, " beats"}, 64'(fwd), 64'(nb));
    // RESP
    req_w_valid_i = '0;
    req_w_last_i = '0;
    mst_w_ready_i = 1'b1;
    mst_b_valid_i = 1'b1;
    mst_b_resp_i = resp;
    for (int c = 0; c <= b_dly; c++) begin
      req_b_ready_i = ~oh;
      req_b_ready_i[w] = (c == b_dly);
      #1;
      chk({tag, " r busy"}, 64'(busy_o), 1);
      chk({tag, " r b_vld"}, 64'(req_b_valid_o), 64'(oh));
      chk({tag, " r resp"}, 64'(req_b_resp_o), 64'(resp));
      chk({tag, " r m_brdy"}, 64'(mst_b_ready_o), 64'(c == b_dly));
      chk({tag, " r m_wv"}, 64'(mst_w_valid_o), 0);
      chk({tag, " r aw_rdy"}, 64'(req_aw_ready_o), 0);
      @(negedge clk);
    end
    mst_b_valid_i = 1'b0;
    req_b_ready_i = '0;
    mst_w_ready_i = 1'b0;
    ptr_m = (w + 1) % NR;
    #1;
    chk_quiet({tag, " done"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NR-1:0] m;
    rst_i = 1'b1;
    req_aw_addr_i = '0;
    req_w_data_i = '0;
    req_w_strb_i = '0;
    clear_inputs();
    @(negedge clk);
    do_reset("reset");

    raise(0, 32'h1000);
    do_txn("single", 1, 32'hDEADBEEF, 0, 0, 0, RESP_OKAY, '0, -1);

    do_reset("reset2");
    raise(0, 32'h2000);
    raise(1, 32'h3000);
    do_txn("rr_a", 1, 32'h11110000, 0, 0, 0, RESP_OKAY, '0, -1);
    do_txn("rr_b", 1, 32'h22220000, 1, 0, 0, RESP_OKAY, '0, -1);
    raise(0, 32'h2100);
    raise(1, 32'h3100);
    do_txn("rr_c", 1, 32'h33330000, 0, 0, 0, RESP_OKAY, '0, -1);
    do_txn("rr_d", 1, 32'h44440000, 0, 0, 0, RESP_OKAY, '0, -1);

    raise(0, 32'h4000);
    do_txn("burst", 4, 32'hA0000000, 0, 1, 0, RESP_OKAY, '0, -1);

    raise(1, 32'h5000);
    do_txn("slverr", 1, 32'h55555555, 0, 0, 3, RESP_SLVERR, '0, -1);

    raise(0, 32'h6000);
    do_txn("late0", 2, 32'h66660000, 0, 0, 0, RESP_OKAY, 2'b10, -1);
    do_txn("late1", 1, 32'h77770000, 0, 0, 0, RESP_OKAY, '0, -1);

    raise(0, 32'h8000);
    do_txn("abort", 4, 32'h88880000, 0, 0, 0, RESP_OKAY, '0, 2);
    raise(0, 32'h8100);
    raise(1, 32'h9100);
    do_txn("post_a", 1, 32'h99990000, 0, 0, 0, RESP_OKAY, '0, -1);
    do_txn("post_b", 3, 32'h9A9A0000, 2, 2, 1, RESP_SLVERR, '0, -1);

    for (int t = 0; t < 40; t++) begin
      m = NR'($urandom_range(0, (1 << NR) - 1));
      if (req_aw_valid_i == '0 && m == '0) m[$urandom_range(0, NR - 1)] = 1'b1;
      for (int i = 0; i < NR; i++)
        if (m[i] && !req_aw_valid_i[i]) raise(i, AW'($urandom));
      do_txn("rand", $urandom_range(1, 4), DW'($urandom),
             $urandom_range(0, 2), 2, $urandom_range(0, 2),
             2'($urandom_range(0, 3)), NR'($urandom_range(0, 3)), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
